// File: rtl/nf_mem_arb_if.sv
// Bundle of the nf_mem_arb buses: fetch requester, load/store requester and
// the shared single-ported memory. The arbiter connects through the slave
// modport. The master modport is the environment side (requesters plus memory).
interface nf_mem_arb_if;

  // instruction-fetch requester
  logic [31:0] i_addr;
  logic        i_req;
  logic        i_req_ack;
  logic [31:0] i_rd;

  // load/store requester
  logic [31:0] d_addr;
  logic [31:0] d_wd;
  logic        d_we;
  logic        d_req;
  logic        d_req_ack;
  logic [31:0] d_rd;

  // shared memory bus
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic        m_we;
  logic        m_req;
  logic        m_ack;
  logic [31:0] m_rd;

  // arbiter view
  modport slave (
    input  i_addr, i_req,
    input  d_addr, d_wd, d_we, d_req,
    input  m_ack, m_rd,
    output i_req_ack, i_rd,
    output d_req_ack, d_rd,
    output m_addr, m_wd, m_we, m_req
  );

  // requesters and memory view
  modport master (
    output i_addr, i_req,
    output d_addr, d_wd, d_we, d_req,
    output m_ack, m_rd,
    input  i_req_ack, i_rd,
    input  d_req_ack, d_rd,
    input  m_addr, m_wd, m_we, m_req
  );

endinterface

// File: rtl/nf_mem_arb.sv
// nf_mem_arb: shares one single-ported memory bus between instruction fetch
// and load/store. Data has fixed priority; a starvation counter forces a
// fetch grant after STARVE_MAX consecutive data grants that overtook a
// pending fetch. Every output is a register. One access is in flight at a time.
module nf_mem_arb #(
  parameter int STARVE_MAX = 4  // must be >= 1
) (
  input  logic          clk,
  input  logic          resetn,
  nf_mem_arb_if.slave   bus
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] starve_cnt_reg;
  logic [31:0]   m_addr_reg;
  logic [31:0]   m_wd_reg;
  logic          m_we_reg;
  logic          m_req_reg;
  logic          i_ack_reg;
  logic          d_ack_reg;
  logic [31:0]   i_rd_reg;
  logic [31:0]   d_rd_reg;

  logic i_live;
  logic d_live;
  logic starved;
  logic grant_d;
  logic grant_i;

  // A request whose ack is being presented this cycle is the one that just
  // finished, so it must not be re-granted. Data wins unless fetch is starved.
  always_comb begin
    i_live  = bus.i_req & ~i_ack_reg;
    d_live  = bus.d_req & ~d_ack_reg;
    starved = (starve_cnt_reg == STARVE_LIM);
    grant_d = d_live & ~(i_live & starved);
    grant_i = i_live & ~grant_d;
  end

  // Arbitration FSM: grant in IDLE, hold the memory request until m_ack,
  // then return the read data and a one-cycle ack to the winner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      m_addr_reg     <= '0;
      m_wd_reg       <= '0;
      m_we_reg       <= 1'b0;
      m_req_reg      <= 1'b0;
      i_ack_reg      <= 1'b0;
      d_ack_reg      <= 1'b0;
      i_rd_reg       <= '0;
      d_rd_reg       <= '0;
    end else begin
      // acks are single-cycle pulses
      i_ack_reg <= 1'b0;
      d_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            m_addr_reg <= bus.d_addr;
            m_wd_reg   <= bus.d_wd;
            m_we_reg   <= bus.d_we;
            m_req_reg  <= 1'b1;
            state_reg  <= D_BUSY;
            // count only grants that overtook a waiting fetch; saturate
            if (i_live) begin
              if (!starved) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
              end
            end else begin
              starve_cnt_reg <= '0;
            end
          end else if (grant_i) begin
            // fetch never writes; m_wd keeps its last value
            m_addr_reg     <= bus.i_addr;
            m_we_reg       <= 1'b0;
            m_req_reg      <= 1'b1;
            state_reg      <= I_BUSY;
            starve_cnt_reg <= '0;
          end
        end
        I_BUSY: begin
          if (bus.m_ack) begin
            m_req_reg <= 1'b0;
            i_rd_reg  <= bus.m_rd;
            i_ack_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        D_BUSY: begin
          if (bus.m_ack) begin
            m_req_reg <= 1'b0;
            // a write leaves the last read data in place
            if (!m_we_reg) begin
              d_rd_reg <= bus.m_rd;
            end
            d_ack_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // registered outputs onto the bus
  assign bus.m_addr    = m_addr_reg;
  assign bus.m_wd      = m_wd_reg;
  assign bus.m_we      = m_we_reg;
  assign bus.m_req     = m_req_reg;
  assign bus.i_req_ack = i_ack_reg;
  assign bus.d_req_ack = d_ack_reg;
  assign bus.i_rd      = i_rd_reg;
  assign bus.d_rd      = d_rd_reg;

endmodule

// File: tb/tb_nf_mem_arb.sv
// Self-checking bench for nf_mem_arb: a transaction-level reference model is
// stepped every cycle, a table of single accesses is replayed, hand-written
// sequences cover priority, starvation and reset, and a random phase follows.
module tb_nf_mem_arb;

  localparam int STARVE_MAX = 4;
  localparam logic [31:0] FA = 32'hF000_0000;  // fetch address in arbitration runs
  localparam logic [31:0] DA = 32'hD000_0000;  // data address in arbitration runs

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  nf_mem_arb_if bus();

  nf_mem_arb #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad = 0;

  // reference model state
  int          owner;      // 0 idle, 1 fetch in flight, 2 data in flight
  int          starve;
  logic [31:0] lat_addr;
  logic [31:0] lat_wd;
  logic        lat_we;
  logic        exp_i_ack, exp_d_ack;
  logic [31:0] exp_i_rd, exp_d_rd;

  // inputs as seen at the last rising edge
  logic        p_i_req, p_d_req, p_d_we, p_m_ack;
  logic [31:0] p_i_addr, p_d_addr, p_d_wd, p_m_rd;

  logic [31:0] mem [logic [31:0]];
  int          dut_log[$];

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          we;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] exp_i_rd;
    logic [31:0] exp_d_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = 0; starve = 0;
    lat_addr = '0; lat_wd = '0; lat_we = 1'b0;
    exp_i_ack = 1'b0; exp_d_ack = 1'b0;
    exp_i_rd = '0; exp_d_rd = '0;
  endtask

  // Advance the model by the edge just taken and compare every output.
  task automatic step();
    logic il, dl, gd, gi;
    logic ni, nd;
    ni = 1'b0; nd = 1'b0;
    if (owner == 0) begin
      il = p_i_req && !exp_i_ack;
      dl = p_d_req && !exp_d_ack;
      gd = dl && !(il && starve == STARVE_MAX);
      gi = il && !gd;
      if (gd) begin
        owner = 2; lat_addr = p_d_addr; lat_wd = p_d_wd; lat_we = p_d_we;
        if (il) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
        else    starve = 0;
      end else if (gi) begin
        owner = 1; lat_addr = p_i_addr; lat_we = 1'b0; starve = 0;
      end
    end else if (p_m_ack) begin
      if (owner == 1) begin
        exp_i_rd = p_m_rd; ni = 1'b1;
      end else begin
        if (!lat_we) exp_d_rd = p_m_rd;
        nd = 1'b1;
      end
      owner = 0;
    end
    exp_i_ack = ni; exp_d_ack = nd;
    chk("m_req", 32'(bus.m_req), 32'(owner != 0));
    if (owner != 0) begin
      chk("m_addr", bus.m_addr, lat_addr);
      chk("m_we", 32'(bus.m_we), 32'(lat_we));
      if (lat_we) chk("m_wd", bus.m_wd, lat_wd);
    end
    chk("i_req_ack", 32'(bus.i_req_ack), 32'(exp_i_ack));
    chk("d_req_ack", 32'(bus.d_req_ack), 32'(exp_d_ack));
    chk("i_rd", bus.i_rd, exp_i_rd);
    chk("d_rd", bus.d_rd, exp_d_rd);
    chk("starve_cnt", 32'(dut.starve_cnt_reg), 32'(starve));
  endtask

  // One clock: remember inputs at the edge, then check at the falling edge.
  task automatic tick();
    p_i_req = bus.i_req; p_i_addr = bus.i_addr;
    p_d_req = bus.d_req; p_d_addr = bus.d_addr; p_d_wd = bus.d_wd; p_d_we = bus.d_we;
    p_m_ack = bus.m_ack; p_m_rd = bus.m_rd;
    @(posedge clk);
    @(negedge clk);
    step();
  endtask

  task automatic do_txn(input vec_t v);
    if (v.is_d) begin
      bus.d_addr = v.addr; bus.d_wd = v.wd; bus.d_we = v.we; bus.d_req = 1'b1;
    end else begin
      bus.i_addr = v.addr; bus.i_req = 1'b1;
    end
    bus.m_ack = 1'b0;
    tick();
    chk("vec m_req", 32'(bus.m_req), 32'd1);
    chk("vec m_addr", bus.m_addr, v.addr);
    chk("vec m_we", 32'(bus.m_we), 32'(v.is_d && v.we));
    if (v.is_d && v.we) chk("vec m_wd", bus.m_wd, v.wd);
    for (int w = 0; w < v.waits; w++) begin
      // late changes on the requester side must not reach the bus
      if (v.is_d) begin bus.d_addr = ~v.addr; bus.d_wd = ~v.wd; end
      else bus.i_addr = ~v.addr;
      tick();
      chk("vec hold m_addr", bus.m_addr, v.addr);
      chk("vec hold m_req", 32'(bus.m_req), 32'd1);
    end
    bus.m_ack = 1'b1; bus.m_rd = v.rdata;
    tick();
    chk("vec ack", 32'(v.is_d ? bus.d_req_ack : bus.i_req_ack), 32'd1);
    chk("vec i_rd", bus.i_rd, v.exp_i_rd);
    chk("vec d_rd", bus.d_rd, v.exp_d_rd);
    bus.m_ack = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick();
  endtask

  // Finish whatever is in flight and leave the arbiter idle.
  task automatic drain();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    for (int c = 0; c < 20 && bus.m_req; c++) begin
      bus.m_ack = 1'b1; bus.m_rd = $urandom;
      tick();
    end
    bus.m_ack = 1'b0;
    tick(); tick();
    chk("drain idle", 32'(bus.m_req), 32'd0);
  endtask

  initial begin
    logic pm;
    int   wcnt;

    vecs[0] = '{1'b1, 32'h0000_2000, 32'h1234_5678, 1'b1, 3, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b1, 32'h0000_0040, 32'h0000_0000, 1'b0, 0, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'hA5A5_A5A5};
    vecs[2] = '{1'b0, 32'h0000_0104, 32'h0000_0000, 1'b0, 1, 32'h00C0_FFEE, 32'h00C0_FFEE, 32'hA5A5_A5A5};
    vecs[3] = '{1'b1, 32'h0000_0044, 32'hCAFE_F00D, 1'b1, 2, 32'h1357_2468, 32'h00C0_FFEE, 32'hA5A5_A5A5};
    vecs[4] = '{1'b1, 32'h0000_0048, 32'h0000_0000, 1'b0, 5, 32'h5A5A_1234, 32'h00C0_FFEE, 32'h5A5A_1234};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5A5A_1234};

    bus.i_addr = '0; bus.i_req = 1'b0;
    bus.d_addr = '0; bus.d_wd = '0; bus.d_we = 1'b0; bus.d_req = 1'b0;
    bus.m_ack = 1'b0; bus.m_rd = '0;
    model_reset();

    // reset values
    repeat (2) @(negedge clk);
    chk("rst m_req", 32'(bus.m_req), 32'd0);
    chk("rst m_addr", bus.m_addr, 32'd0);
    chk("rst m_wd", bus.m_wd, 32'd0);
    chk("rst m_we", 32'(bus.m_we), 32'd0);
    chk("rst i_req_ack", 32'(bus.i_req_ack), 32'd0);
    chk("rst d_req_ack", 32'(bus.d_req_ack), 32'd0);
    chk("rst i_rd", bus.i_rd, 32'd0);
    chk("rst d_rd", bus.d_rd, 32'd0);
    chk("rst starve", 32'(dut.starve_cnt_reg), 32'd0);
    resetn = 1'b1;

    // single zero-wait fetch, req still high in its ack cycle
    bus.i_addr = 32'h100; bus.i_req = 1'b1;
    tick();
    chk("t1 m_req", 32'(bus.m_req), 32'd1);
    chk("t1 m_addr", bus.m_addr, 32'h100);
    chk("t1 m_we", 32'(bus.m_we), 32'd0);
    bus.m_ack = 1'b1; bus.m_rd = 32'hDEAD_BEEF;
    tick();
    chk("t1 i_req_ack", 32'(bus.i_req_ack), 32'd1);
    chk("t1 i_rd", bus.i_rd, 32'hDEAD_BEEF);
    bus.m_ack = 1'b0;
    tick();
    chk("t1 no regrant", 32'(bus.m_req), 32'd0);
    bus.i_req = 1'b0;
    tick();

    // single accesses from the table
    for (int k = 0; k < 6; k++) do_txn(vecs[k]);

    // simultaneous requests: data first, fetch granted in the data ack cycle
    bus.i_addr = 32'h200; bus.i_req = 1'b1;
    bus.d_addr = 32'h300; bus.d_we = 1'b0; bus.d_req = 1'b1;
    tick();
    chk("t3 data first", bus.m_addr, 32'h300);
    bus.m_ack = 1'b1; bus.m_rd = 32'h1111_1111;
    tick();
    chk("t3 d_req_ack", 32'(bus.d_req_ack), 32'd1);
    chk("t3 d_rd", bus.d_rd, 32'h1111_1111);
    bus.d_req = 1'b0; bus.m_ack = 1'b0;
    tick();
    chk("t3 fetch m_req", 32'(bus.m_req), 32'd1);
    chk("t3 fetch addr", bus.m_addr, 32'h200);
    bus.m_ack = 1'b1; bus.m_rd = 32'h2222_2222;
    tick();
    chk("t3 i_rd", bus.i_rd, 32'h2222_2222);
    drain();

    // both held continuously: masking alternates the ports
    dut_log.delete();
    bus.i_addr = FA; bus.i_req = 1'b1;
    bus.d_addr = DA; bus.d_we = 1'b0; bus.d_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      pm = bus.m_req;
      bus.m_ack = bus.m_req; bus.m_rd = $urandom;
      tick();
      if (bus.m_req && !pm) dut_log.push_back(bus.m_addr == FA ? 1 : 2);
    end
    chk("t4a grants", 32'(dut_log.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < dut_log.size(); k++)
      chk("t4a order", 32'(dut_log[k]), (k % 2 == 0) ? 32'd2 : 32'd1);
    drain();

    // fetch drops out during each data ack cycle: data overtakes it until starved
    dut_log.delete();
    bus.d_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      pm = bus.m_req;
      bus.m_ack = bus.m_req; bus.m_rd = $urandom;
      bus.i_req = !bus.d_req_ack;
      tick();
      if (bus.m_req && !pm) begin
        dut_log.push_back(bus.m_addr == FA ? 1 : 2);
        if (bus.m_addr == FA && dut_log.size() == 5)
          chk("t4b starve clear", 32'(dut.starve_cnt_reg), 32'd0);
      end
    end
    chk("t4b grants", 32'(dut_log.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < dut_log.size(); k++)
      chk("t4b order", 32'(dut_log[k]), (k == 4) ? 32'd1 : 32'd2);
    drain();

    // reset while a data access is outstanding
    bus.d_addr = 32'h500; bus.d_we = 1'b0; bus.d_req = 1'b1;
    tick();
    chk("t5 busy", 32'(bus.m_req), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t5 async m_req", 32'(bus.m_req), 32'd0);
    chk("t5 async m_addr", bus.m_addr, 32'd0);
    chk("t5 async d_rd", bus.d_rd, 32'd0);
    chk("t5 async i_rd", bus.i_rd, 32'd0);
    model_reset();
    bus.d_req = 1'b0; bus.m_ack = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    bus.d_addr = 32'h600; bus.d_req = 1'b1;
    tick();
    chk("t5 fresh grant", bus.m_addr, 32'h600);
    bus.m_ack = 1'b1; bus.m_rd = 32'h0BAD_F00D;
    tick();
    chk("t5 fresh ack", 32'(bus.d_req_ack), 32'd1);
    chk("t5 fresh d_rd", bus.d_rd, 32'h0BAD_F00D);
    drain();

    // random traffic against a memory with random wait states
    wcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.m_req) begin
        bus.m_ack = 1'b0; wcnt = $urandom_range(0, 3);
      end else if (wcnt > 0) begin
        wcnt--; bus.m_ack = 1'b0;
      end else begin
        bus.m_ack = 1'b1;
        if (bus.m_we) begin
          mem[bus.m_addr] = bus.m_wd; bus.m_rd = $urandom;
        end else begin
          bus.m_rd = mem.exists(bus.m_addr) ? mem[bus.m_addr] : ~bus.m_addr;
        end
      end
      if (bus.i_req_ack || !bus.i_req) begin
        bus.i_req = ($urandom_range(0, 2) == 0);
        bus.i_addr = 32'($urandom_range(0, 63)) << 2;
      end else if (owner == 1) begin
        bus.i_addr = $urandom;
      end
      if (bus.d_req_ack || !bus.d_req) begin
        bus.d_req = ($urandom_range(0, 2) == 0);
        bus.d_addr = 32'($urandom_range(0, 63)) << 2;
        bus.d_wd = $urandom; bus.d_we = $urandom_range(0, 1) == 1;
      end else if (owner == 2) begin
        bus.d_addr = $urandom; bus.d_wd = $urandom; bus.d_we = ~bus.d_we;
      end
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
